// File: rtl/timestamp_sched_pkg.sv
// Shared definitions for the timestamp-scheduled pulse generator:
// state encoding, event-word field layout and counter width.
package timestamp_sched_pkg;

    typedef enum logic [2:0] {
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_WAIT,
        ST_FIRE
    } state_e;

    localparam int ID_MSB   = 31;
    localparam int ID_LSB   = 28;
    localparam int IDX_MSB  = 27;
    localparam int IDX_LSB  = 24;
    localparam int PAY_MSB  = 23;
    localparam int W_MSB    = 23;
    localparam int W_LSB    = 16;
    localparam int THI_MSB  = 15;

    localparam logic [3:0] IDX_T0 = 4'd0;
    localparam logic [3:0] IDX_T1 = 4'd1;
    localparam logic [3:0] IDX_T2 = 4'd2;

    localparam int CNT_W = 8;

    function automatic logic word_ok(
        input logic [31:0] word,
        input logic [3:0]  ident,
        input logic [3:0]  idx
    );
        return (word[ID_MSB:ID_LSB] == ident) && (word[IDX_MSB:IDX_LSB] == idx);
    endfunction

endpackage

// File: rtl/timestamp_sched_pulse_sat_counter.sv
// Saturating event counter with synchronous active-high clear.
// Holds at all-ones; one increment per cycle at most.
module sat_counter
    import timestamp_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/timestamp_sched_pulse.sv
// Pops 3-word event records from a FWFT FIFO, waits for EXT_TIMESTAMP to reach
// the target time and drives PULSE for W+1 cycles; late/malformed input is counted.
module timestamp_sched_pulse
    import timestamp_sched_pkg::*;
#(
    parameter logic [3:0] IDENTIFIER = 4'b0101
) (
    input  logic             BUS_CLK,
    input  logic             BUS_RST,
    input  logic             ENABLE,
    input  logic             FIFO_EMPTY,
    input  logic [31:0]      FIFO_DATA,
    output logic             FIFO_READ,
    input  logic [63:0]      EXT_TIMESTAMP,
    output logic             PULSE,
    output logic             BUSY,
    output logic [CNT_W-1:0] LATE_COUNT,
    output logic [CNT_W-1:0] FMT_ERR_COUNT
);

    state_e      state_q, state_d;
    logic [63:0] t_q, t_d;
    logic [7:0]  w_q, w_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pulse_q;
    logic        pop;
    logic        late_inc;
    logic        fmt_inc;
    logic [63:0] t_full;

    // Full target time as it will look once the idx-2 word is latched.
    assign t_full = {FIFO_DATA[THI_MSB:0], t_q[47:0]};

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        late_inc = 1'b0;
        fmt_inc  = 1'b0;

        case (state_q)
            ST_RD0: begin
                if (ENABLE && !FIFO_EMPTY) begin
                    pop = 1'b1;
                    if (word_ok(FIFO_DATA, IDENTIFIER, IDX_T0)) begin
                        t_d[23:0] = FIFO_DATA[PAY_MSB:0];
                        state_d   = ST_RD1;
                    end else begin
                        fmt_inc = 1'b1;
                    end
                end
            end
            ST_RD1: begin
                if (!FIFO_EMPTY) begin
                    pop = 1'b1;
                    if (word_ok(FIFO_DATA, IDENTIFIER, IDX_T1)) begin
                        t_d[47:24] = FIFO_DATA[PAY_MSB:0];
                        state_d    = ST_RD2;
                    end else begin
                        fmt_inc = 1'b1;
                        state_d = ST_RD0;
                    end
                end
            end
            ST_RD2: begin
                if (!FIFO_EMPTY) begin
                    pop = 1'b1;
                    if (word_ok(FIFO_DATA, IDENTIFIER, IDX_T2)) begin
                        t_d = t_full;
                        w_d = FIFO_DATA[W_MSB:W_LSB];
                        if (t_full < EXT_TIMESTAMP) begin
                            late_inc = 1'b1;
                            state_d  = ST_RD0;
                        end else if (t_full == EXT_TIMESTAMP) begin
                            cnt_d   = FIFO_DATA[W_MSB:W_LSB];
                            state_d = ST_FIRE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        fmt_inc = 1'b1;
                        state_d = ST_RD0;
                    end
                end
            end
            ST_WAIT: begin
                // >= rather than == so a forward jump of the time base still fires.
                if (EXT_TIMESTAMP >= t_q) begin
                    cnt_d   = w_q;
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RD0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_RD0;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q <= ST_RD0;
            t_q     <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            // Registered from the next state so PULSE rises one cycle after the fire condition.
            pulse_q <= (state_d == ST_FIRE);
        end
    end

    sat_counter u_late_cnt (
        .clk_i   (BUS_CLK),
        .rst_i   (BUS_RST),
        .inc_i   (late_inc),
        .count_o (LATE_COUNT)
    );

    sat_counter u_fmt_cnt (
        .clk_i   (BUS_CLK),
        .rst_i   (BUS_RST),
        .inc_i   (fmt_inc),
        .count_o (FMT_ERR_COUNT)
    );

    // No pop while in reset: the FIFO is not flushed and must not lose a word.
    assign FIFO_READ = pop && !BUS_RST;
    assign PULSE     = pulse_q;
    assign BUSY      = (state_q != ST_RD0);

endmodule

// File: tb/tb_timestamp_sched_pulse.sv
// Bench for timestamp_sched_pulse: directed scenarios plus a randomized phase,
// all checked every cycle against a record-level reference model.
module tb_timestamp_sched_pulse;

    localparam logic [3:0] ID = 4'b0101;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        empty;
    logic [31:0] data;
    logic        rd;
    logic [63:0] ts;
    logic        pulse;
    logic        busy;
    logic [7:0]  late_c;
    logic [7:0]  fmt_c;

    always #5 clk = ~clk;

    timestamp_sched_pulse #(.IDENTIFIER(ID)) dut (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .ENABLE        (en),
        .FIFO_EMPTY    (empty),
        .FIFO_DATA     (data),
        .FIFO_READ     (rd),
        .EXT_TIMESTAMP (ts),
        .PULSE         (pulse),
        .BUSY          (busy),
        .LATE_COUNT    (late_c),
        .FMT_ERR_COUNT (fmt_c)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] fq[$];
    bit          gate;
    logic [63:0] ts_step;

    // Reference model: words collected so far for the current record (3 = complete,
    // waiting for its time), remaining pulse cycles, and the two event tallies.
    int          m_have;
    int          m_left;
    logic [63:0] m_T;
    logic [7:0]  m_W;
    int          m_late;
    int          m_fmt;

    int          n_pulse;
    int          n_read;
    logic [63:0] rise_ts;
    bit          seen_rise;
    bit          prev_pulse;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input logic [3:0] id, input logic [3:0] idx,
                                        input logic [23:0] p);
        return {id, idx, p};
    endfunction

    task automatic push_rec(input logic [63:0] t, input logic [7:0] w);
        fq.push_back(mkw(ID, 4'd0, t[23:0]));
        fq.push_back(mkw(ID, 4'd1, t[47:24]));
        fq.push_back(mkw(ID, 4'd2, {w, t[63:48]}));
    endtask

    task automatic clr_stats();
        n_pulse   = 0;
        n_read    = 0;
        rise_ts   = '0;
        seen_rise = 1'b0;
    endtask

    task automatic cyc();
        bit          rd_exp;
        logic [31:0] w;
        empty = gate || (fq.size() == 0);
        data  = (fq.size() != 0) ? fq[0] : 32'h0BAD_F00D;
        @(negedge clk);
        rd_exp = !rst && !empty && (m_left == 0) &&
                 ((m_have == 0 && en) || m_have == 1 || m_have == 2);
        chk("fifo_read", rd, rd_exp);
        chk("pulse", pulse, m_left > 0);
        chk("busy", busy, (m_have != 0) || (m_left > 0));
        chk("late_count", late_c, m_late);
        chk("fmt_err_count", fmt_c, m_fmt);
        if (pulse === 1'b1) n_pulse++;
        if (rd === 1'b1) n_read++;
        if (pulse === 1'b1 && !prev_pulse && !seen_rise) begin
            rise_ts   = ts;
            seen_rise = 1'b1;
        end
        prev_pulse = (pulse === 1'b1);

        if (rst) begin
            m_have = 0; m_left = 0; m_late = 0; m_fmt = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_have == 3) begin
            if (ts >= m_T) begin
                m_left = int'(m_W) + 1;
                m_have = 0;
            end
        end else if (rd_exp) begin
            w = fq[0];
            if (w[31:28] != ID || w[27:24] != m_have[3:0]) begin
                m_fmt  = (m_fmt < 255) ? m_fmt + 1 : 255;
                m_have = 0;
            end else if (m_have == 0) begin
                m_T[23:0] = w[23:0];
                m_have    = 1;
            end else if (m_have == 1) begin
                m_T[47:24] = w[23:0];
                m_have     = 2;
            end else begin
                m_T[63:48] = w[15:0];
                m_W        = w[23:16];
                if (m_T < ts) begin
                    m_late = (m_late < 255) ? m_late + 1 : 255;
                    m_have = 0;
                end else if (m_T == ts) begin
                    m_left = int'(m_W) + 1;
                    m_have = 0;
                end else begin
                    m_have = 3;
                end
            end
        end

        @(posedge clk);
        #1;
        if (rd_exp) void'(fq.pop_front());
        ts = ts + ts_step;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] t;
        logic [7:0]  w;
        int          k;

        rst = 1'b1; en = 1'b0; gate = 1'b0; ts = '0; ts_step = 64'd1;
        empty = 1'b1; data = '0;
        m_have = 0; m_left = 0; m_T = '0; m_W = '0; m_late = 0; m_fmt = 0;
        prev_pulse = 1'b0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run(2);
        en = 1'b1;

        // Basic fire
        ts = 64'd100;
        push_rec(64'd120, 8'd3);
        clr_stats();
        run(30);
        chk("s1_pulse_len", n_pulse, 4);
        chk("s1_reads", n_read, 3);
        chk("s1_rise_ts", rise_ts, 64'd121);
        chk("s1_late", late_c, 0);

        // Late drop
        ts = 64'd500;
        push_rec(64'd400, 8'd0);
        clr_stats();
        run(6);
        chk("s2_late", late_c, 1);
        chk("s2_no_pulse", n_pulse, 0);

        // Format errors, then a valid single-cycle record
        fq.push_back(mkw(4'b0011, 4'd0, 24'h000123));
        fq.push_back(mkw(ID, 4'd1, 24'h000456));
        run(4);
        chk("s3_fmt", fmt_c, 2);
        chk("s3_idle", busy, 0);
        push_rec(ts + 64'd10, 8'd0);
        clr_stats();
        run(20);
        chk("s3_pulse_len", n_pulse, 1);

        // Back-to-back, second record late
        do_reset();
        ts = 64'd40;
        push_rec(64'd50, 8'd0);
        push_rec(64'd52, 8'd0);
        clr_stats();
        run(25);
        chk("s4_rise_ts", rise_ts, 64'd51);
        chk("s4_late", late_c, 1);
        chk("s4_pulse_len", n_pulse, 1);

        // Stalled words, ENABLE dropped after the first pop
        do_reset();
        ts = 64'd1000;
        push_rec(64'd1030, 8'd2);
        push_rec(64'd1010, 8'd0);
        clr_stats();
        for (int i = 0; i < 45; i++) begin
            gate = (i % 5) != 0;
            cyc();
            if (n_read >= 1) en = 1'b0;
        end
        chk("s5_held", fq.size(), 3);
        chk("s5_pulse_len", n_pulse, 3);
        chk("s5_rise_ts", rise_ts, 64'd1031);
        gate = 1'b0;
        en   = 1'b1;
        run(10);
        chk("s5_late", late_c, 1);

        // Reset in the middle of a long pulse
        do_reset();
        ts = 64'd2000;
        fq.push_back(mkw(4'b1111, 4'd0, 24'h0));
        push_rec(64'd2010, 8'd10);
        clr_stats();
        run(16);
        chk("s6_in_pulse", pulse, 1);
        do_reset();
        chk("s6_pulse_dropped", pulse, 0);
        chk("s6_fmt_cleared", fmt_c, 0);
        chk("s6_busy_cleared", busy, 0);
        push_rec(ts + 64'd10, 8'd1);
        clr_stats();
        run(20);
        chk("s6_refire_len", n_pulse, 2);

        // Format-error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) fq.push_back(mkw(ID, 4'd3, 24'h0));
        run(305);
        chk("sat_fmt", fmt_c, 255);

        // Randomized traffic with high timestamp bits in play
        do_reset();
        ts = 64'h1234_0000_0000_0000 + 64'($urandom);
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            gate    = ($urandom_range(0, 3) == 0);
            ts_step = ($urandom_range(0, 49) == 0) ? 64'($urandom_range(2, 200))
                    : (($urandom_range(0, 9) == 0) ? 64'd0 : 64'd1);
            if (fq.size() < 4 && $urandom_range(0, 7) == 0) begin
                t = ts + 64'($urandom_range(0, 60)) - 64'd10;
                w = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
                push_rec(t, w);
                if ($urandom_range(0, 5) == 0) begin
                    k = fq.size() - 1 - int'($urandom_range(0, 2));
                    fq[k] = fq[k] ^ (32'd1 << (24 + $urandom_range(0, 7)));
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst     = 1'b0;
        ts_step = 64'd1;
        gate    = 1'b0;
        run(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
